regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
Writeback/commit unit that drives the regfile write port (rd, in_data). It accepts results from the EXU and the LSU and extends load data per funct3, buffering LSU results in a 2-entry FIFO. It commits at most one write per cycle. It also keeps a 32-bit pending-write scoreboard and raises a hazard flag for decode when a source register has an outstanding write.

Parameters:
LSU_FIFO_DEPTH, 2, LSU result buffer entries; power of two, >=2.
XLEN, 32, data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
issue_valid  in  1  decode issues an instruction with a destination this cycle.
issue_rd  in  5  destination of the issued instruction.
rs1  in  5  decode source 1 query.
rs2  in  5  decode source 2 query.
hazard  out  1  combinational; a queried source has a pending write.
exu_valid  in  1  EXU result valid.
exu_ready  out  1  EXU result accepted when valid & ready.
exu_rd  in  5  EXU destination.
exu_data  in  XLEN  EXU result.
lsu_valid  in  1  LSU load data valid.
lsu_ready  out  1  LSU handshake ready.
lsu_rd  in  5  load destination.
lsu_funct3  in  3  load type.
lsu_addr_lo  in  2  byte offset of the load address.
lsu_data  in  XLEN  raw aligned memory word.
rd  out  5  regfile write index; 0 = no write.
in_data  out  XLEN  regfile write data.
busy_mask  out  32  scoreboard; bit i = write to xi pending.

Behaviour:
- Reset (async, rst=1): rd=0, in_data=0, busy_mask=0, FIFO empty, exu_ready=0, lsu_ready=0. Any in-flight results are discarded.
- Ready signals:
  - lsu_ready = !rst & (fifo_count < LSU_FIFO_DEPTH).
  - exu_ready = !rst & (fifo_count < LSU_FIFO_DEPTH).
  - With a full FIFO, the FIFO drains first.
- LSU acceptance (lsu_valid & lsu_ready):
  - Data is extended before enqueue.
  - funct3 000 LB: sign-extend byte at offset addr_lo*8.
  - funct3 001 LH: sign-extend half at addr_lo[1]*16.
  - funct3 010 LW: full word.
  - funct3 100 LBU / 101 LHU: zero-extend.
  - Other funct3 values: treat as LW.
  - lsu_rd=0: accepted but not enqueued.
- Commit arbitration, one per cycle:
  - If fifo_count==DEPTH: FIFO head commits; EXU is not accepted (exu_ready=0).
  - Else if EXU is accepted with exu_rd!=0: EXU commits.
  - Else if FIFO is non-empty: head commits.
  - Else: no commit.
  - Enqueue and dequeue in the same cycle keep the count unchanged. Enqueue into an empty FIFO does not commit the same cycle; commit is earliest the next cycle.
- Output register:
  - On commit, rd/in_data load the winner at the edge. Otherwise rd<=0 and in_data holds its value.
  - The regfile samples rd/in_data at the following edge, so result-to-regfile latency is 2 edges.
- Scoreboard:
  - At each edge, the bit for the current nonzero rd output clears (write lands this edge).
  - issue_valid & issue_rd!=0 sets bit issue_rd.
  - If both hit the same index at the same edge, set wins.
  - Bit 0 is always 0.
- hazard = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]). No bypass; decode stalls.
- Reset asserted mid-operation clears everything immediately. A result accepted in the same cycle as reset assertion is lost.

Test Plan:
1. Reset, then EXU valid rd=2 data=32'hf0f0feec -> exu_ready=1. rd=2/in_data=f0f0feec one cycle later. busy[2] cleared after that cycle.
2. issue rd=3, then rs1=3 -> hazard=1. EXU commit to x3 -> hazard=0 the cycle after rd=3 is output. Issue and commit of x3 on the same edge -> busy[3] stays 1.
3. LSU LB with data=32'h0000_8000, addr_lo=1 -> in_data=ffff_ff80. LBU -> 0000_0080. LH with data=32'h8001_0000, addr_lo=2 -> ffff_8001. funct3=011 -> full word.
4. EXU and LSU valid every cycle -> the first two LSU results queue and lsu_ready drops. The FIFO head then commits while exu_ready=0. No result is lost or duplicated, and commit order per source is preserved.
5. EXU rd=0 and LSU rd=0 -> both accepted, rd output stays 0, busy_mask unchanged.
6. Assert rst with FIFO holding 2 entries and busy_mask nonzero -> rd=0, busy_mask=0, readies 0 asynchronously. After release, readies=1 and no stale commit appears.

Source files
------------

// File: rtl/regfile_wb_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_if
// Bundles every non-clock signal of the writeback unit:
//   decode side : issue_valid/issue_rd (destination issue), rs1/rs2 (queries),
//                 hazard (pending-write flag)
//   EXU side    : exu_valid/exu_ready handshake, exu_rd, exu_data
//   LSU side    : lsu_valid/lsu_ready handshake, lsu_rd, lsu_funct3,
//                 lsu_addr_lo, lsu_data (raw aligned word)
//   regfile     : rd (write index, 0 = no write), in_data (write data)
//   status      : busy_mask (pending-write scoreboard)
// master drives the requests, slave is the writeback unit.
// ----------------------------------------------------------------------------
interface regfile_wb_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard;
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [2:0]      lsu_funct3;
  logic [1:0]      lsu_addr_lo;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      rd;
  logic [XLEN-1:0] in_data;
  logic [31:0]     busy_mask;

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_data,
    input  hazard, exu_ready, lsu_ready, rd, in_data, busy_mask
  );

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_data,
    output hazard, exu_ready, lsu_ready, rd, in_data, busy_mask
  );
endinterface

// File: rtl/regfile_wb.sv
// ----------------------------------------------------------------------------
// regfile_wb
// Writeback/commit unit feeding the register file write port.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_wb_if.slave (decode issue/query, EXU and LSU result
//         handshakes, regfile write port, scoreboard)
// LSU results are extended and buffered in a small FIFO; EXU results are
// committed directly. At most one regfile write is presented per cycle, and
// a full FIFO always drains ahead of new EXU results.
// ----------------------------------------------------------------------------
module regfile_wb #(
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int XLEN           = 32
) (
  input  logic          clk,
  input  logic          rst,
  regfile_wb_if.slave   bus
);

  localparam int PW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Load data extension: select byte/half by address offset, then sign- or
  // zero-extend; undefined funct3 encodings pass the word through.
  function automatic logic [XLEN-1:0] f_load_extend(
    input logic [2:0]      funct3,
    input logic [1:0]      addr_lo,
    input logic [XLEN-1:0] data
  );
    logic [XLEN-1:0] v_sh_b;
    logic [XLEN-1:0] v_sh_h;
    logic [7:0]      v_b;
    logic [15:0]     v_h;
    logic [XLEN-1:0] v_res;
    v_sh_b = data >> {addr_lo, 3'b000};
    v_sh_h = data >> {addr_lo[1], 4'b0000};
    v_b    = v_sh_b[7:0];
    v_h    = v_sh_h[15:0];
    case (funct3)
      3'b000:  v_res = {{(XLEN-8){v_b[7]}}, v_b};
      3'b001:  v_res = {{(XLEN-16){v_h[15]}}, v_h};
      3'b100:  v_res = {{(XLEN-8){1'b0}}, v_b};
      3'b101:  v_res = {{(XLEN-16){1'b0}}, v_h};
      default: v_res = data;
    endcase
    return v_res;
  endfunction

  logic [4:0]      r_fifo_rd   [LSU_FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [LSU_FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_in_data;
  logic [31:0]     r_busy;

  logic            w_full;
  logic            w_ready;
  logic            w_exu_acc;
  logic            w_lsu_acc;
  logic            w_enq;
  logic            w_deq;
  logic            w_commit;
  logic [4:0]      w_c_rd;
  logic [XLEN-1:0] w_c_data;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_set_mask;

  assign w_full    = (r_count == CW'(LSU_FIFO_DEPTH));
  // Readies fall with rst directly so nothing is accepted while in reset.
  assign w_ready   = ~rst & ~w_full;
  assign w_exu_acc = bus.exu_valid & w_ready;
  assign w_lsu_acc = bus.lsu_valid & w_ready;
  // Loads to x0 complete the handshake but are dropped.
  assign w_enq     = w_lsu_acc & (bus.lsu_rd != 5'd0);

  // Commit arbitration: full FIFO first, then EXU, then any buffered load.
  always_comb begin
    w_deq    = 1'b0;
    w_commit = 1'b0;
    w_c_rd   = r_fifo_rd[r_rptr];
    w_c_data = r_fifo_data[r_rptr];
    if (w_full) begin
      w_deq    = 1'b1;
      w_commit = 1'b1;
    end else if (w_exu_acc && (bus.exu_rd != 5'd0)) begin
      w_commit = 1'b1;
      w_c_rd   = bus.exu_rd;
      w_c_data = bus.exu_data;
    end else if (r_count != {CW{1'b0}}) begin
      w_deq    = 1'b1;
      w_commit = 1'b1;
    end else begin
      w_commit = 1'b0;
    end
  end

  // LSU result FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
        r_fifo_rd[i]   <= 5'd0;
        r_fifo_data[i] <= {XLEN{1'b0}};
      end
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_enq) begin
        r_fifo_rd[r_wptr]   <= bus.lsu_rd;
        r_fifo_data[r_wptr] <= f_load_extend(bus.lsu_funct3, bus.lsu_addr_lo, bus.lsu_data);
        r_wptr              <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Regfile write port register; in_data holds between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd      <= 5'd0;
      r_in_data <= {XLEN{1'b0}};
    end else if (w_commit) begin
      r_rd      <= w_c_rd;
      r_in_data <= w_c_data;
    end else begin
      r_rd      <= 5'd0;
    end
  end

  // The write presented on rd lands this edge, so its pending bit clears;
  // a new issue to the same register re-sets it (set wins).
  assign w_clr_mask = (r_rd != 5'd0) ? (32'd1 << r_rd) : 32'd0;
  assign w_set_mask = (bus.issue_valid && (bus.issue_rd != 5'd0)) ? (32'd1 << bus.issue_rd) : 32'd0;

  // Pending-write scoreboard; x0 is never pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  assign bus.hazard    = ((bus.rs1 != 5'd0) & r_busy[bus.rs1]) |
                         ((bus.rs2 != 5'd0) & r_busy[bus.rs2]);
  assign bus.exu_ready = w_ready;
  assign bus.lsu_ready = w_ready;
  assign bus.rd        = r_rd;
  assign bus.in_data   = r_in_data;
  assign bus.busy_mask = r_busy;

endmodule

// File: tb/tb_regfile_wb.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb
// Random and directed stimulus against a queue-based reference model. Each
// stimulus cycle pushes the expected regfile write into exp_q; a monitor on
// the falling edge pops and compares whenever the DUT shows rd != 0.
// ----------------------------------------------------------------------------
module tb_regfile_wb;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_if #(.XLEN(32)) bus ();

  regfile_wb #(.LSU_FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wr_t         exp_q [$];
  wr_t         mfifo [$];
  logic [31:0] mbusy    = 32'd0;
  logic [4:0]  m_rd_cur = 5'd0;
  int          n_cmp    = 0;
  int          n_err    = 0;
  wr_t         mon_e;

  logic        s_ev, s_lv, s_iv;
  logic [4:0]  s_erd, s_lrd, s_ird, s_q1, s_q2;
  logic [31:0] s_ed, s_ld;
  logic [2:0]  s_lf3;
  logic [1:0]  s_loff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference load extension from plain arithmetic on the word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(off))) & 32'h0000_00ff;
    h = (d >> (16 * (int'(off) / 2))) & 32'h0000_ffff;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hffff_ff00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hffff_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // Monitor: every regfile write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && bus.rd != 5'd0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_commit: got rd=%0d data=%h expected no write", bus.rd, bus.in_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_rd", 32'(bus.rd), 32'(mon_e.rd));
        check("commit_data", bus.in_data, mon_e.data);
      end
    end
  end

  task automatic clear_stim();
    s_ev = 1'b0; s_erd = 5'd0; s_ed = 32'd0;
    s_lv = 1'b0; s_lrd = 5'd0; s_lf3 = 3'd0; s_loff = 2'd0; s_ld = 32'd0;
    s_iv = 1'b0; s_ird = 5'd0; s_q1 = 5'd0; s_q2 = 5'd0;
  endtask

  task automatic drive();
    bus.exu_valid   = s_ev;  bus.exu_rd = s_erd; bus.exu_data = s_ed;
    bus.lsu_valid   = s_lv;  bus.lsu_rd = s_lrd; bus.lsu_funct3 = s_lf3;
    bus.lsu_addr_lo = s_loff; bus.lsu_data = s_ld;
    bus.issue_valid = s_iv;  bus.issue_rd = s_ird;
    bus.rs1         = s_q1;  bus.rs2 = s_q2;
  endtask

  // One cycle: drive, check combinational outputs, advance the model, clock.
  task automatic step();
    logic       rdy;
    logic       haz;
    logic [4:0] nrd;
    wr_t        w;
    drive();
    #1;
    rdy = (mfifo.size() < DEPTH);
    haz = ((s_q1 != 5'd0) && mbusy[s_q1]) || ((s_q2 != 5'd0) && mbusy[s_q2]);
    check("exu_ready", 32'(bus.exu_ready), 32'(rdy));
    check("lsu_ready", 32'(bus.lsu_ready), 32'(rdy));
    check("hazard", 32'(bus.hazard), 32'(haz));
    check("busy_mask", bus.busy_mask, mbusy);
    nrd = 5'd0;
    if (!rdy) begin
      w = mfifo.pop_front();
      exp_q.push_back(w);
      nrd = w.rd;
    end else if (s_ev && s_erd != 5'd0) begin
      w = '{rd: s_erd, data: s_ed};
      exp_q.push_back(w);
      nrd = w.rd;
    end else if (mfifo.size() > 0) begin
      w = mfifo.pop_front();
      exp_q.push_back(w);
      nrd = w.rd;
    end
    if (rdy && s_lv && s_lrd != 5'd0) begin
      mfifo.push_back('{rd: s_lrd, data: ref_load(s_lf3, s_loff, s_ld)});
    end
    if (m_rd_cur != 5'd0) mbusy[m_rd_cur] = 1'b0;
    if (s_iv && s_ird != 5'd0) mbusy[s_ird] = 1'b1;
    m_rd_cur = nrd;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clear_stim();
    for (int i = 0; i < 8 && (exp_q.size() > 0 || mfifo.size() > 0); i++) step();
    step();
  endtask

  task automatic load_test(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] d, input logic [31:0] expv);
    clear_stim();
    s_lv = 1'b1; s_lrd = 5'd7; s_lf3 = f3; s_loff = off; s_ld = d;
    step();
    clear_stim();
    step();
    check(name, bus.in_data, expv);
  endtask

  initial begin
    clear_stim();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", 32'(bus.rd), 32'd0);
    check("reset_in_data", bus.in_data, 32'd0);
    check("reset_busy", bus.busy_mask, 32'd0);
    check("reset_exu_ready", 32'(bus.exu_ready), 32'd0);
    check("reset_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // EXU write to x2 after issuing x2
    clear_stim(); s_iv = 1'b1; s_ird = 5'd2; step();
    clear_stim(); s_ev = 1'b1; s_erd = 5'd2; s_ed = 32'hf0f0_feec; step();
    check("exu_rd", 32'(bus.rd), 32'd2);
    check("exu_data", bus.in_data, 32'hf0f0_feec);
    clear_stim(); step();
    check("busy2_cleared", 32'(bus.busy_mask[2]), 32'd0);

    // Hazard on x3, then issue and commit of x3 on the same edge
    clear_stim(); s_iv = 1'b1; s_ird = 5'd3; step();
    clear_stim(); s_q1 = 5'd3; step();
    check("hazard_set", 32'(bus.hazard), 32'd1);
    clear_stim(); s_q1 = 5'd3; s_ev = 1'b1; s_erd = 5'd3; s_ed = 32'h1234_5678; step();
    clear_stim(); s_q1 = 5'd3; s_iv = 1'b1; s_ird = 5'd3; step();
    check("busy3_kept", 32'(bus.busy_mask[3]), 32'd1);
    clear_stim(); s_q1 = 5'd3; s_ev = 1'b1; s_erd = 5'd3; s_ed = 32'h0bad_cafe; step();
    clear_stim(); s_q1 = 5'd3; step();
    check("hazard_clear", 32'(bus.hazard), 32'd0);

    // Load extension
    load_test("load_lb",  3'b000, 2'd1, 32'h0000_8000, 32'hffff_ff80);
    load_test("load_lbu", 3'b100, 2'd1, 32'h0000_8000, 32'h0000_0080);
    load_test("load_lh",  3'b001, 2'd2, 32'h8001_0000, 32'hffff_8001);
    load_test("load_011", 3'b011, 2'd3, 32'hdead_beef, 32'hdead_beef);

    // EXU and LSU valid every cycle
    for (int i = 0; i < 10; i++) begin
      clear_stim();
      s_ev = 1'b1; s_erd = 5'($urandom_range(1, 31)); s_ed = $urandom();
      s_lv = 1'b1; s_lrd = 5'($urandom_range(1, 31)); s_ld = $urandom();
      s_lf3 = 3'($urandom_range(0, 7)); s_loff = 2'($urandom_range(0, 3));
      step();
    end
    drain();

    // rd=0 results on both sources
    clear_stim(); s_ev = 1'b1; s_lv = 1'b1; s_ed = 32'h5555_aaaa; s_ld = 32'h1111_2222; step();
    clear_stim(); step();
    check("rd0_no_write", 32'(bus.rd), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_ev   = 1'($urandom_range(0, 1));
      s_erd  = 5'($urandom_range(0, 31));
      s_ed   = $urandom();
      s_lv   = 1'($urandom_range(0, 1));
      s_lrd  = 5'($urandom_range(0, 31));
      s_lf3  = 3'($urandom_range(0, 7));
      s_loff = 2'($urandom_range(0, 3));
      s_ld   = $urandom();
      s_iv   = 1'($urandom_range(0, 1));
      s_ird  = 5'($urandom_range(0, 31));
      s_q1   = 5'($urandom_range(0, 31));
      s_q2   = 5'($urandom_range(0, 31));
      step();
    end
    drain();

    // Reset mid-operation with two buffered loads and pending writes
    clear_stim(); s_iv = 1'b1; s_ird = 5'd9; step();
    clear_stim(); s_ev = 1'b1; s_erd = 5'd10; s_ed = 32'd1;
    s_lv = 1'b1; s_lrd = 5'd11; s_ld = 32'd2; s_lf3 = 3'd2; step();
    s_erd = 5'd12; s_lrd = 5'd13; step();
    clear_stim(); s_ev = 1'b1; s_erd = 5'd14; s_lv = 1'b1; s_lrd = 5'd15;
    drive();
    #1;
    check("full_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_busy", bus.busy_mask, 32'd0);
    check("rst_exu_ready", 32'(bus.exu_ready), 32'd0);
    check("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    exp_q.delete();
    mfifo.delete();
    mbusy    = 32'd0;
    m_rd_cur = 5'd0;
    clear_stim();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(bus.exu_ready), 32'd1);
    for (int i = 0; i < 4; i++) step();

    @(negedge clk);
    #1;
    check("expected_all_seen", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
